// File: rtl/ones_accum.sv
// Frame accumulator for {cout,sum} weights from the full-adder reduction stage.
// Sums FRAME_LEN samples (or fewer on flush), saturating, with a held result.
module ones_accum #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sum,
  input  logic             in_cout,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [7:0]       out_count,
  output logic             out_sat
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] FLEN = 8'(FRAME_LEN);
  localparam logic [ACC_W+1:0] MAXV = {2'b00, {ACC_W{1'b1}}};

  state_t           state_q, state_d;
  logic             live_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] tot_q, tot_d;
  logic [7:0]       ocnt_q, ocnt_d;
  logic             osat_q, osat_d;

  logic             accept;
  logic             ovf;
  logic             close;
  logic [ACC_W+1:0] sum_w;

  assign in_ready  = live_q && (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_total = tot_q;
  assign out_count = ocnt_q;
  assign out_sat   = osat_q;

  assign accept = in_valid && in_ready;
  assign sum_w  = {2'b00, acc_q} + {{ACC_W{1'b0}}, in_cout, in_sum};
  assign ovf    = (sum_w > MAXV);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    tot_d   = tot_q;
    ocnt_d  = ocnt_q;
    osat_d  = osat_q;
    close   = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = ovf ? MAXV[ACC_W-1:0] : sum_w[ACC_W-1:0];
          cnt_d = cnt_q + 8'd1;
          sat_d = sat_q | ovf;
        end
        // an empty frame is never emitted, so a bare flush needs cnt>0
        close = (accept && ((cnt_d == FLEN) || flush))
             || (flush && (cnt_q != 8'd0));
        if (close) begin
          state_d = HOLD;
          tot_d   = acc_d;
          ocnt_d  = cnt_d;
          osat_d  = sat_d;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      live_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      tot_q   <= '0;
      ocnt_q  <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      tot_q   <= tot_d;
      ocnt_q  <= ocnt_d;
      osat_q  <= osat_d;
    end
  end

endmodule

// File: tb/tb_ones_accum.sv
// Bench for ones_accum: ACC_W=5 and ACC_W=4 instances share one stimulus
// stream and are compared against a frame-level reference model.
module tb_ones_accum;

  localparam int FL = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sum = 1'b0;
  logic       in_cout = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic       rdy5, rdy4, vld5, vld4, sat5, sat4;
  logic [4:0] tot5;
  logic [3:0] tot4;
  logic [7:0] cnt5, cnt4;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  int  frame[$];
  bit  m_live = 0;
  bit  m_hold = 0;
  int  m_sum = 0;
  int  m_cnt = 0;

  always #5 clk = ~clk;

  ones_accum #(.FRAME_LEN(FL), .ACC_W(5)) u5 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy5),
    .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
    .out_valid(vld5), .out_ready(out_ready), .out_total(tot5),
    .out_count(cnt5), .out_sat(sat5)
  );

  ones_accum #(.FRAME_LEN(FL), .ACC_W(4)) u4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
    .out_valid(vld4), .out_ready(out_ready), .out_total(tot4),
    .out_count(cnt4), .out_sat(sat4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clip(input int s, input int w);
    int mx = (1 << w) - 1;
    return (s > mx) ? mx : s;
  endfunction

  task automatic check_outputs();
    chk("in_ready5", 32'(rdy5), 32'(m_live && !m_hold));
    chk("in_ready4", 32'(rdy4), 32'(m_live && !m_hold));
    chk("out_valid5", 32'(vld5), 32'(m_hold));
    chk("out_valid4", 32'(vld4), 32'(m_hold));
    if (m_hold) begin
      chk("total5", 32'(tot5), 32'(clip(m_sum, 5)));
      chk("total4", 32'(tot4), 32'(clip(m_sum, 4)));
      chk("count5", 32'(cnt5), 32'(m_cnt));
      chk("count4", 32'(cnt4), 32'(m_cnt));
      chk("sat5", 32'(sat5), 32'(m_sum > 31));
      chk("sat4", 32'(sat4), 32'(m_sum > 15));
    end
  endtask

  // one clock: apply inputs, advance model at the edge, check after it
  task automatic step(input bit v, input int w, input bit f, input bit ordy);
    bit take;
    in_valid  = v;
    in_sum    = v ? w[0] : 1'bx;
    in_cout   = v ? w[1] : 1'bx;
    flush     = f;
    out_ready = ordy;
    @(posedge clk);
    if (m_hold) begin
      if (ordy) begin
        m_hold = 0;
        frame.delete();
      end
    end else if (m_live) begin
      take = v;
      if (take) frame.push_back(w);
      if (f ? (frame.size() > 0) : (frame.size() == FL)) begin
        m_hold = 1;
        m_sum  = frame.sum();
        m_cnt  = frame.size();
      end
    end
    m_live = 1;
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready5"}, 32'(rdy5), 0);
    chk({tag, "_ready4"}, 32'(rdy4), 0);
    chk({tag, "_valid5"}, 32'(vld5), 0);
    chk({tag, "_valid4"}, 32'(vld4), 0);
    chk({tag, "_total5"}, 32'(tot5), 0);
    chk({tag, "_count5"}, 32'(cnt5), 0);
    chk({tag, "_sat5"}, 32'(sat5), 0);
  endtask

  initial begin
    // reset state
    #3;
    check_reset_values("rst");
    #4 reset_n = 1'b1;
    @(posedge clk);
    m_live = 1;
    #1;
    check_outputs();

    // eight w=3 back to back: 24 / saturated 15 on the narrow instance
    for (int i = 0; i < FL; i++) step(1, 3, 0, 0);
    chk("t1_total5", 32'(tot5), 24);
    chk("t1_total4", 32'(tot4), 15);
    chk("t1_sat4", 32'(sat4), 1);
    step(1, 3, 0, 1);

    // sticky sat cleared: eight w=1
    for (int i = 0; i < FL; i++) step(1, 1, 0, 0);
    chk("t2_total4", 32'(tot4), 8);
    chk("t2_sat4", 32'(sat4), 0);
    step(0, 0, 0, 1);

    // weights with gaps, result held 5 cycles while HOLD ignores valid/flush
    for (int i = 0; i < FL; i++) begin
      step(1, i % 4, 0, 0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) step(1, 3, 1, 0);
    chk("t3_total5", 32'(tot5), 12);
    chk("t3_count5", 32'(cnt5), 8);
    step(1, 2, 0, 1);
    chk("t3_ready", 32'(rdy5), 1);

    // flush with a same-cycle sample, then a flush on an empty frame
    for (int i = 0; i < 3; i++) step(1, 2, 0, 0);
    step(1, 1, 1, 0);
    chk("t4_total5", 32'(tot5), 7);
    chk("t4_count5", 32'(cnt5), 4);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("t4_noframe", 32'(vld5), 0);

    // asynchronous reset mid-frame discards the partial sum
    for (int i = 0; i < 5; i++) step(1, 3, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    frame.delete();
    m_live = 0;
    m_hold = 0;
    check_reset_values("arst");
    #1 reset_n = 1'b1;
    step(0, 0, 0, 0);
    for (int i = 0; i < FL; i++) step(1, 1, 0, 0);
    chk("t5_total5", 32'(tot5), 8);
    chk("t5_count5", 32'(cnt5), 8);
    step(0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, int'($urandom % 4),
           ($urandom % 10) == 0, ($urandom % 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ones_accum.md
Name: ones_accum

Overview:
- Sequential stage directly downstream of the 4-input full-adder reduction stage.
- Consumes one 2-bit weight per handshake, formed as {cout1, sum1} (value 0..3), and accumulates weights over a frame of FRAME_LEN samples.
- Presents the frame total on a valid/ready output, then clears for the next frame.
- Turns the combinational adder tree into a running ones-counter for the datapath labs.

Parameters:
- FRAME_LEN, 8: samples per frame; legal range 2..255.
- ACC_W, 5: accumulator width in bits; the total saturates at 2^ACC_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present.
- in_ready  output  1  stage accepts a sample this cycle.
- in_sum  input  1  sum bit from the upstream adder stage (weight 1).
- in_cout  input  1  carry bit from the upstream adder stage (weight 2).
- flush  input  1  close the current frame early.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer takes the result.
- out_total  output  ACC_W  accumulated weight of the frame.
- out_count  output  8  number of samples in the frame.
- out_sat  output  1  accumulator saturated during the frame.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=ACCUM, acc=0, cnt=0, sat=0.
  - out_valid=0, out_total=0, out_count=0, out_sat=0.
  - in_ready=0 while reset_n is low; in_ready=1 from the first clock edge after release.
- Accept: in_valid & in_ready at a rising edge. Weight w = 2*in_cout + in_sum.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - On accept: acc <= min(acc+w, 2^ACC_W-1); cnt <= cnt+1.
  - sat <= 1 if the unclipped acc+w exceeds 2^ACC_W-1. sat is sticky until the frame is cleared.
  - Addition is done at ACC_W+2 bits, then clipped.
- Frame close, ACCUM -> HOLD:
  - An accept that makes cnt reach FRAME_LEN closes the frame.
  - flush=1 with cnt>0, or with an accept in the same cycle, also closes the frame. The same-cycle sample is included in the total.
  - flush=1 with cnt==0 and no accept is ignored; no empty frames are produced.
- HOLD state:
  - Results are registered: out_total, out_count and out_sat are loaded at the closing edge. out_valid=1 in the cycle after the last accept (latency 1).
  - in_ready=0; in_valid and flush are ignored.
  - Outputs stay stable while out_ready=0.
  - On out_valid & out_ready: acc=0, cnt=0, sat=0, state -> ACCUM. out_valid drops and in_ready rises at that edge. No output-to-input combinational bypass.
  - out_total, out_count and out_sat hold their last values after out_valid drops. They are don't-care when out_valid=0.
- Throughput: one frame per FRAME_LEN+1 cycles, minimum.
- No combinational path from any input to any output. in_ready and out_valid decode from the state register only.
- Asserting reset_n low mid-frame or in HOLD discards all partial data immediately, with no output pulse.
- X on in_sum/in_cout is tolerated when in_valid=0.

Test Plan:
- Reset, then 8 accepts of w=3 ({1,1}) back-to-back -> out_valid the cycle after the 8th accept; out_total=24, out_count=8, out_sat=0; in_ready=0 during HOLD.
- Weights 0,1,2,3,0,1,2,3 with in_valid gaps, out_ready held low 5 cycles -> out_total=12, out_count=8, stable for all 5 cycles; out_ready=1 -> next cycle in_ready=1, new frame starts at 0.
- ACC_W=4, eight samples of w=3 -> out_total=15, out_sat=1. The following frame of eight w=1 -> out_total=8, out_sat=0 (sticky flag cleared).
- 3 accepts of w=2, then flush together with a 4th accept of w=1 -> out_total=7, out_count=4. A flush with cnt=0 -> no out_valid.
- reset_n pulsed low asynchronously, between edges, after 5 accepts -> out_valid=0 at once. Next full frame of w=1 -> out_total=8, out_count=8, with no leftover partial sum.
- Valid asserted in HOLD with flush=1 -> no accept, no change to outputs; the sample is accepted only after release.
